mission_sequencer: RTL and testbench

Parametrised mission-step sequencer that replaces the hard-coded top-level state machine driving the Navigation block. It steps through a table of step descriptors. For each step it loads COMMAND, PATH and COMPARE_DISTANCE from constants or live sonar distances, waits for NEXT_FLAG, and optionally waits for an operator confirm edge. It adds per-step timeout/error recovery, saturating distance arithmetic, bounded looping and a DONE terminal state. It sits between the sensor/localization outputs and the Navigation inputs.

---
 rtl/mission_pkg.sv | 45 ++++
 rtl/mission_step_rom.sv | 36 +++
 rtl/mission_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_mission_sequencer.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mission_pkg.sv
// Shared command codes, status codes, source selects and step descriptor layout
// for the mission sequencer and its step table.
package mission_pkg;

    localparam int DESC_W = 8;

    localparam logic [4:0] NO_COMMAND = 5'b00000;
    localparam logic [4:0] TURN_RIGHT = 5'b01100;
    localparam logic [4:0] TURN_LEFT  = 5'b00110;
    localparam logic [4:0] STRAIGHT   = 5'b01110;

    localparam logic [1:0] RF_INI = 2'b00;
    localparam logic [1:0] RF_EXC = 2'b01;
    localparam logic [1:0] RF_COM = 2'b10;
    localparam logic [1:0] RF_ERR = 2'b11;

    typedef enum logic [2:0] {
        SRC_CONST,
        SRC_FRONT,
        SRC_SIDE_FRONT,
        SRC_RIGHT,
        SRC_KEEP
    } src_e;

    typedef struct packed {
        logic [4:0]        cmd;
        src_e              path_src;
        logic [DESC_W-1:0] path_const;
        src_e              cmp_src;
        logic [DESC_W-1:0] cmp_const;
        logic [DESC_W-1:0] cmp_offset;
        logic              confirm_req;
        logic [DESC_W-1:0] next;
    } step_desc_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INI,
        ST_EXC,
        ST_COM,
        ST_ERR,
        ST_DONE
    } state_e;

endpackage

// File: rtl/mission_step_rom.sv
// Mission table: step index to descriptor, purely combinational.
// Editing the mission means editing only the case table below.
module mission_step_rom
    import mission_pkg::*;
#(
    parameter int STEP_W  = 3,
    parameter int N_STEPS = 5
) (
    input  logic [STEP_W-1:0] idx_i,
    output step_desc_t        desc_o
);

    always_comb begin
        desc_o = '{cmd: NO_COMMAND, path_src: SRC_KEEP, path_const: '0, cmp_src: SRC_CONST,
                   cmp_const: '0, cmp_offset: '0, confirm_req: 1'b0, next: DESC_W'(N_STEPS)};
        case (idx_i)
            STEP_W'(0): desc_o = '{cmd: STRAIGHT, path_src: SRC_SIDE_FRONT, path_const: '0,
                                   cmp_src: SRC_FRONT, cmp_const: '0, cmp_offset: DESC_W'(15),
                                   confirm_req: 1'b1, next: DESC_W'(1)};
            STEP_W'(1): desc_o = '{cmd: TURN_LEFT, path_src: SRC_KEEP, path_const: '0,
                                   cmp_src: SRC_SIDE_FRONT, cmp_const: '0, cmp_offset: '0,
                                   confirm_req: 1'b1, next: DESC_W'(2)};
            STEP_W'(2): desc_o = '{cmd: STRAIGHT, path_src: SRC_CONST, path_const: DESC_W'(5),
                                   cmp_src: SRC_CONST, cmp_const: DESC_W'(12), cmp_offset: '0,
                                   confirm_req: 1'b1, next: DESC_W'(3)};
            STEP_W'(3): desc_o = '{cmd: TURN_RIGHT, path_src: SRC_KEEP, path_const: '0,
                                   cmp_src: SRC_RIGHT, cmp_const: '0, cmp_offset: '0,
                                   confirm_req: 1'b0, next: DESC_W'(4)};
            STEP_W'(4): desc_o = '{cmd: STRAIGHT, path_src: SRC_CONST, path_const: DESC_W'(16),
                                   cmp_src: SRC_CONST, cmp_const: DESC_W'(12), cmp_offset: '0,
                                   confirm_req: 1'b0, next: DESC_W'(3)};
            default:    desc_o.next = DESC_W'(N_STEPS);
        endcase
    end

endmodule

// File: rtl/mission_sequencer.sv
// Table-driven mission sequencer feeding the Navigation block; all outputs registered.
// Non-confirm step turnaround is 3 cycles from NEXT_FLAG to the new COMMAND.
module mission_sequencer
    import mission_pkg::*;
#(
    parameter int DIST_W         = 8,
    parameter int CMD_W          = 5,
    parameter int N_STEPS        = 5,
    parameter int STEP_W         = 3,
    parameter int TIMEOUT_CYCLES = 500_000_000,
    parameter int TO_W           = 30,
    parameter int LOOP_MAX       = 0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic              ADVANCE,
    input  logic              RETRY,
    input  logic              ABORT,
    input  logic              NEXT_FLAG,
    input  logic [DIST_W-1:0] DISTANCE_FRONT,
    input  logic [DIST_W-1:0] DISTANCE_SIDE_FRONT,
    input  logic [DIST_W-1:0] RIGHT_DISTANCE,
    output logic [CMD_W-1:0]  COMMAND,
    output logic [DIST_W-1:0] PATH,
    output logic [DIST_W-1:0] COMPARE_DISTANCE,
    output logic [1:0]        RUN_FLAG,
    output logic [STEP_W-1:0] STEP,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERROR,
    output logic [DIST_W-1:0] INITIAL_X,
    output logic [DIST_W-1:0] INITIAL_Y
);

    localparam int LOOP_W = 16;
    localparam logic [LOOP_W-1:0] LOOP_LAST = LOOP_W'((LOOP_MAX == 0) ? 0 : LOOP_MAX - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_e            state_q;
    logic [CMD_W-1:0]  cmd_q;
    logic [DIST_W-1:0] path_q, cmp_q, ix_q, iy_q;
    logic [1:0]        run_flag_q;
    logic [STEP_W-1:0] step_q;
    logic              busy_q, done_q, error_q;
    logic [LOOP_W-1:0] loop_q;
    logic [TO_W-1:0]   to_q;
    logic [1:0]        adv_q, retry_q;

    step_desc_t        desc;
    logic [DIST_W-1:0] path_d, cmp_src_d, cmp_off_d, cmp_d;
    logic [STEP_W-1:0] next_step;
    logic              adv_rise, retry_rise, is_term, is_back, loop_hit, timed_out;

    mission_step_rom #(
        .STEP_W  (STEP_W),
        .N_STEPS (N_STEPS)
    ) u_rom (
        .idx_i  (step_q),
        .desc_o (desc)
    );

    always_comb begin
        path_d = path_q;
        case (desc.path_src)
            SRC_CONST:      path_d = DIST_W'(desc.path_const);
            SRC_FRONT:      path_d = DISTANCE_FRONT;
            SRC_SIDE_FRONT: path_d = DISTANCE_SIDE_FRONT;
            SRC_RIGHT:      path_d = RIGHT_DISTANCE;
            default:        path_d = path_q;
        endcase
        cmp_src_d = cmp_q;
        case (desc.cmp_src)
            SRC_CONST:      cmp_src_d = DIST_W'(desc.cmp_const);
            SRC_FRONT:      cmp_src_d = DISTANCE_FRONT;
            SRC_SIDE_FRONT: cmp_src_d = DISTANCE_SIDE_FRONT;
            SRC_RIGHT:      cmp_src_d = RIGHT_DISTANCE;
            default:        cmp_src_d = cmp_q;
        endcase
        // Threshold saturates at zero rather than wrapping to a huge stop distance.
        cmp_off_d = DIST_W'(desc.cmp_offset);
        cmp_d     = (cmp_src_d > cmp_off_d) ? (cmp_src_d - cmp_off_d) : '0;
    end

    assign adv_rise   = adv_q[0] & ~adv_q[1];
    assign retry_rise = retry_q[0] & ~retry_q[1];
    assign next_step  = STEP_W'(desc.next);
    assign is_term    = (desc.next == DESC_W'(N_STEPS));
    assign is_back    = (next_step <= step_q);
    assign loop_hit   = (LOOP_MAX != 0) && is_back && (loop_q == LOOP_LAST);
    assign timed_out  = (TIMEOUT_CYCLES != 0) && (to_q == TO_LAST);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            cmd_q      <= CMD_W'(NO_COMMAND);
            path_q     <= '0;
            cmp_q      <= '0;
            run_flag_q <= RF_INI;
            step_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            ix_q       <= '0;
            iy_q       <= '0;
            loop_q     <= '0;
            to_q       <= '0;
            adv_q      <= '0;
            retry_q    <= '0;
        end else begin
            adv_q   <= {adv_q[0], ADVANCE};
            retry_q <= {retry_q[0], RETRY};
            if (ABORT) begin
                state_q    <= ST_IDLE;
                cmd_q      <= CMD_W'(NO_COMMAND);
                path_q     <= '0;
                cmp_q      <= '0;
                run_flag_q <= RF_INI;
                step_q     <= '0;
                busy_q     <= 1'b0;
                done_q     <= 1'b0;
                error_q    <= 1'b0;
                loop_q     <= '0;
                to_q       <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (!START) begin
                            ix_q <= DISTANCE_SIDE_FRONT;
                            iy_q <= DISTANCE_FRONT;
                        end else begin
                            state_q    <= ST_INI;
                            step_q     <= '0;
                            run_flag_q <= RF_INI;
                            busy_q     <= 1'b1;
                        end
                    end
                    ST_INI: begin
                        cmd_q      <= CMD_W'(desc.cmd);
                        path_q     <= path_d;
                        cmp_q      <= cmp_d;
                        to_q       <= '0;
                        state_q    <= ST_EXC;
                        run_flag_q <= RF_EXC;
                    end
                    ST_EXC: begin
                        if (NEXT_FLAG) begin
                            state_q    <= ST_COM;
                            run_flag_q <= RF_COM;
                        end else if (timed_out) begin
                            state_q    <= ST_ERR;
                            run_flag_q <= RF_ERR;
                            error_q    <= 1'b1;
                            cmd_q      <= CMD_W'(NO_COMMAND);
                        end else begin
                            to_q <= to_q + 1'b1;
                        end
                    end
                    ST_COM: begin
                        if (!desc.confirm_req || adv_rise) begin
                            if (is_term || loop_hit) begin
                                state_q <= ST_DONE;
                                cmd_q   <= CMD_W'(NO_COMMAND);
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                            end else begin
                                step_q     <= next_step;
                                loop_q     <= is_back ? loop_q + 1'b1 : loop_q;
                                state_q    <= ST_INI;
                                run_flag_q <= RF_INI;
                            end
                        end
                    end
                    ST_ERR: begin
                        if (retry_rise) begin
                            error_q    <= 1'b0;
                            state_q    <= ST_INI;
                            run_flag_q <= RF_INI;
                        end
                    end
                    ST_DONE: done_q <= 1'b1;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign COMMAND          = cmd_q;
    assign PATH             = path_q;
    assign COMPARE_DISTANCE = cmp_q;
    assign RUN_FLAG         = run_flag_q;
    assign STEP             = step_q;
    assign BUSY             = busy_q;
    assign DONE             = done_q;
    assign ERROR            = error_q;
    assign INITIAL_X        = ix_q;
    assign INITIAL_Y        = iy_q;

endmodule

// File: tb/tb_mission_sequencer.sv
// Scenario bench for mission_sequencer with a table-level reference model of the default mission.
module tb_mission_sequencer;

    localparam int DW = 8;
    localparam int CW = 5;
    localparam int SW = 3;
    localparam int TOC = 100;
    localparam int LM = 2;
    localparam logic [4:0] C_NONE  = 5'b00000;
    localparam logic [4:0] C_RIGHT = 5'b01100;
    localparam logic [4:0] C_LEFT  = 5'b00110;
    localparam logic [4:0] C_STR   = 5'b01110;

    logic          CLK = 1'b0;
    logic          RESET, START, ADVANCE, RETRY, ABORT, NEXT_FLAG;
    logic [DW-1:0] DISTANCE_FRONT, DISTANCE_SIDE_FRONT, RIGHT_DISTANCE;
    logic [CW-1:0] COMMAND;
    logic [DW-1:0] PATH, COMPARE_DISTANCE, INITIAL_X, INITIAL_Y;
    logic [1:0]    RUN_FLAG;
    logic [SW-1:0] STEP;
    logic          BUSY, DONE, ERROR;

    int errors = 0;
    int checks = 0;
    int f = 0, sf = 0, r = 0;
    int m_path = 0;

    mission_sequencer #(
        .DIST_W(DW), .CMD_W(CW), .N_STEPS(5), .STEP_W(SW),
        .TIMEOUT_CYCLES(TOC), .TO_W(30), .LOOP_MAX(LM)
    ) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .ADVANCE(ADVANCE), .RETRY(RETRY),
        .ABORT(ABORT), .NEXT_FLAG(NEXT_FLAG), .DISTANCE_FRONT(DISTANCE_FRONT),
        .DISTANCE_SIDE_FRONT(DISTANCE_SIDE_FRONT), .RIGHT_DISTANCE(RIGHT_DISTANCE),
        .COMMAND(COMMAND), .PATH(PATH), .COMPARE_DISTANCE(COMPARE_DISTANCE),
        .RUN_FLAG(RUN_FLAG), .STEP(STEP), .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR),
        .INITIAL_X(INITIAL_X), .INITIAL_Y(INITIAL_Y)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference model: the default mission written as plain per-step rules.
    function automatic logic [4:0] model_cmd(input int s);
        case (s)
            0: return C_STR;
            1: return C_LEFT;
            2: return C_STR;
            3: return C_RIGHT;
            default: return C_STR;
        endcase
    endfunction

    function automatic int model_path(input int s, input int prev, input int sfr);
        case (s)
            0: return sfr;
            2: return 5;
            4: return 16;
            default: return prev;
        endcase
    endfunction

    function automatic logic [7:0] model_cmp(input int s, input int fr, input int sfr, input int rr);
        int v;
        case (s)
            0: v = fr - 15;
            1: v = sfr;
            3: v = rr;
            default: v = 12;
        endcase
        if (v < 0) v = 0;
        return 8'(v);
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic drive_dist(input int fr, input int sfr, input int rr);
        f = fr; sf = sfr; r = rr;
        DISTANCE_FRONT      = 8'(fr);
        DISTANCE_SIDE_FRONT = 8'(sfr);
        RIGHT_DISTANCE      = 8'(rr);
    endtask

    task automatic drive_rand;
        drive_dist($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    endtask

    task automatic wait_rf(input logic [1:0] rf, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i <= budget; i++) begin
            if (RUN_FLAG === rf) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset;
        RESET = 1'b1; START = 1'b0; ADVANCE = 1'b0; RETRY = 1'b0; ABORT = 1'b0; NEXT_FLAG = 1'b0;
        drive_dist(0, 0, 0);
        tick(3);
        checks++;
        if ({COMMAND, PATH, COMPARE_DISTANCE, RUN_FLAG, STEP, BUSY, DONE, ERROR, INITIAL_X, INITIAL_Y} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: cmd=%b path=%0d cmp=%0d rf=%b step=%0d busy=%b done=%b err=%b want all zero",
                     COMMAND, PATH, COMPARE_DISTANCE, RUN_FLAG, STEP, BUSY, DONE, ERROR);
        end
        RESET = 1'b0;
        tick();
    endtask

    task automatic test_capture_launch;
        for (int i = 0; i < 4; i++) begin
            drive_rand();
            tick();
            checks++;
            if (INITIAL_X !== 8'(sf) || INITIAL_Y !== 8'(f)) begin
                errors++;
                $display("FAIL capture_rand: x=%0d y=%0d want x=%0d y=%0d", INITIAL_X, INITIAL_Y, sf, f);
            end
        end
        ADVANCE = 1'b1;
        drive_dist(80, 20, $urandom_range(0, 255));
        tick();
        checks++;
        if (INITIAL_Y !== 8'd80 || INITIAL_X !== 8'd20) begin
            errors++;
            $display("FAIL capture_80_20: x=%0d y=%0d want x=20 y=80", INITIAL_X, INITIAL_Y);
        end
        START = 1'b1;
        tick();
        checks++;
        if (RUN_FLAG !== 2'b00 || BUSY !== 1'b1 || STEP !== 3'd0) begin
            errors++;
            $display("FAIL launch_ini: rf=%b busy=%b step=%0d want rf=00 busy=1 step=0", RUN_FLAG, BUSY, STEP);
        end
        tick();
        checks++;
        if (COMMAND !== C_STR || PATH !== 8'd20 || COMPARE_DISTANCE !== 8'd65 || RUN_FLAG !== 2'b01) begin
            errors++;
            $display("FAIL launch_exc: cmd=%b path=%0d cmp=%0d rf=%b want cmd=01110 path=20 cmp=65 rf=01",
                     COMMAND, PATH, COMPARE_DISTANCE, RUN_FLAG);
        end
        m_path = 20;
    endtask

    task automatic test_confirm;
        bit ok;
        drive_rand();
        NEXT_FLAG = 1'b1; tick(); NEXT_FLAG = 1'b0;
        checks++;
        if (RUN_FLAG !== 2'b10) begin
            errors++;
            $display("FAIL confirm_com: rf=%b want 10", RUN_FLAG);
        end
        tick(6);
        checks++;
        if (RUN_FLAG !== 2'b10 || STEP !== 3'd0) begin
            errors++;
            $display("FAIL confirm_held_level: rf=%b step=%0d want rf=10 step=0", RUN_FLAG, STEP);
        end
        ADVANCE = 1'b0; tick(3); ADVANCE = 1'b1;
        wait_rf(2'b01, 10, ok);
        checks++;
        if (!ok || STEP !== 3'd1 || COMMAND !== model_cmd(1) || PATH !== 8'(m_path)
            || COMPARE_DISTANCE !== model_cmp(1, f, sf, r)) begin
            errors++;
            $display("FAIL confirm_step1: ok=%b step=%0d cmd=%b path=%0d cmp=%0d want step=1 cmd=%b path=%0d cmp=%0d",
                     ok, STEP, COMMAND, PATH, COMPARE_DISTANCE, model_cmd(1), m_path, model_cmp(1, f, sf, r));
        end
        NEXT_FLAG = 1'b1; tick(); NEXT_FLAG = 1'b0;
        tick(6);
        checks++;
        if (STEP !== 3'd1 || RUN_FLAG !== 2'b10) begin
            errors++;
            $display("FAIL confirm_no_skip: step=%0d rf=%b want step=1 rf=10", STEP, RUN_FLAG);
        end
        ADVANCE = 1'b0; tick(3); ADVANCE = 1'b1;
        wait_rf(2'b01, 10, ok);
        m_path = model_path(2, m_path, sf);
        checks++;
        if (!ok || STEP !== 3'd2 || COMMAND !== model_cmd(2) || PATH !== 8'(m_path)
            || COMPARE_DISTANCE !== model_cmp(2, f, sf, r)) begin
            errors++;
            $display("FAIL confirm_step2: ok=%b step=%0d cmd=%b path=%0d cmp=%0d want step=2 cmd=01110 path=5 cmp=12",
                     ok, STEP, COMMAND, PATH, COMPARE_DISTANCE);
        end
    endtask

    task automatic test_timeout_retry;
        bit ok;
        wait_rf(2'b11, TOC + 5, ok);
        checks++;
        if (!ok || ERROR !== 1'b1 || COMMAND !== C_NONE || STEP !== 3'd2) begin
            errors++;
            $display("FAIL timeout_err: ok=%b err=%b cmd=%b step=%0d want err=1 cmd=00000 step=2", ok, ERROR, COMMAND, STEP);
        end
        RETRY = 1'b1;
        wait_rf(2'b01, 10, ok);
        RETRY = 1'b0;
        checks++;
        if (!ok || ERROR !== 1'b0 || STEP !== 3'd2 || COMMAND !== C_STR) begin
            errors++;
            $display("FAIL retry_exc: ok=%b err=%b step=%0d cmd=%b want err=0 step=2 cmd=01110", ok, ERROR, STEP, COMMAND);
        end
        tick(TOC - 1);
        checks++;
        if (ERROR !== 1'b0 || RUN_FLAG !== 2'b01) begin
            errors++;
            $display("FAIL timeout_early: err=%b rf=%b want err=0 rf=01 one cycle before timeout", ERROR, RUN_FLAG);
        end
        tick();
        checks++;
        if (ERROR !== 1'b1 || RUN_FLAG !== 2'b11) begin
            errors++;
            $display("FAIL timeout_exact: err=%b rf=%b want err=1 rf=11", ERROR, RUN_FLAG);
        end
        RETRY = 1'b1;
        wait_rf(2'b01, 10, ok);
        RETRY = 1'b0;
        tick(TOC - 1);
        NEXT_FLAG = 1'b1; tick(); NEXT_FLAG = 1'b0;
        checks++;
        if (!ok || RUN_FLAG !== 2'b10 || ERROR !== 1'b0) begin
            errors++;
            $display("FAIL next_beats_timeout: ok=%b rf=%b err=%b want rf=10 err=0", ok, RUN_FLAG, ERROR);
        end
    endtask

    task automatic test_loop_limit;
        bit ok;
        int s;
        int jumps;
        bit expect_done;
        ADVANCE = 1'b0; tick(3);
        drive_rand();
        ADVANCE = 1'b1;
        wait_rf(2'b01, 10, ok);
        m_path = model_path(3, m_path, sf);
        checks++;
        if (!ok || STEP !== 3'd3 || COMMAND !== model_cmd(3) || PATH !== 8'(m_path)
            || COMPARE_DISTANCE !== model_cmp(3, f, sf, r)) begin
            errors++;
            $display("FAIL loop_step3: ok=%b step=%0d cmd=%b path=%0d cmp=%0d want step=3 cmd=01100 path=%0d cmp=%0d",
                     ok, STEP, COMMAND, PATH, COMPARE_DISTANCE, m_path, model_cmp(3, f, sf, r));
        end
        s = 3; jumps = 0; expect_done = 1'b0;
        for (int k = 0; k < 8 && !expect_done; k++) begin
            int nxt;
            nxt = (s == 3) ? 4 : 3;
            drive_rand();
            NEXT_FLAG = 1'b1; tick(); NEXT_FLAG = 1'b0;
            if (nxt <= s) begin
                if (jumps == LM - 1) expect_done = 1'b1;
                else jumps++;
            end
            if (!expect_done) begin
                tick(2);
                m_path = model_path(nxt, m_path, sf);
                checks++;
                if (RUN_FLAG !== 2'b01 || STEP !== 3'(nxt) || COMMAND !== model_cmd(nxt)
                    || PATH !== 8'(m_path) || COMPARE_DISTANCE !== model_cmp(nxt, f, sf, r)) begin
                    errors++;
                    $display("FAIL loop_walk_%0d: rf=%b step=%0d cmd=%b path=%0d cmp=%0d want rf=01 step=%0d cmd=%b path=%0d cmp=%0d",
                             k, RUN_FLAG, STEP, COMMAND, PATH, COMPARE_DISTANCE, nxt, model_cmd(nxt), m_path,
                             model_cmp(nxt, f, sf, r));
                end
                s = nxt;
            end
        end
        tick();
        checks++;
        if (DONE !== 1'b1 || COMMAND !== C_NONE || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL loop_done: done=%b cmd=%b busy=%b want done=1 cmd=00000 busy=0", DONE, COMMAND, BUSY);
        end
        tick(5);
        checks++;
        if (DONE !== 1'b1 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL done_sticky: done=%b busy=%b want done=1 busy=0", DONE, BUSY);
        end
    endtask

    task automatic test_abort_saturation;
        bit ok;
        START = 1'b0; ABORT = 1'b1; tick(); ABORT = 1'b0;
        checks++;
        if ({COMMAND, PATH, COMPARE_DISTANCE, RUN_FLAG, STEP, BUSY, DONE, ERROR} !== '0) begin
            errors++;
            $display("FAIL abort_from_done: cmd=%b rf=%b step=%0d busy=%b done=%b want all zero",
                     COMMAND, RUN_FLAG, STEP, BUSY, DONE);
        end
        drive_dist($urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 255));
        tick();
        START = 1'b1;
        tick(2);
        m_path = model_path(0, m_path, sf);
        checks++;
        if (COMPARE_DISTANCE !== model_cmp(0, f, sf, r) || COMPARE_DISTANCE !== 8'd0 || PATH !== 8'(m_path)) begin
            errors++;
            $display("FAIL saturation: front=%0d cmp=%0d path=%0d want cmp=0 path=%0d", f, COMPARE_DISTANCE, PATH, m_path);
        end
        for (int k = 0; k < 2; k++) begin
            NEXT_FLAG = 1'b1; tick(); NEXT_FLAG = 1'b0;
            ADVANCE = 1'b0; tick(2); ADVANCE = 1'b1;
            wait_rf(2'b01, 10, ok);
        end
        checks++;
        if (!ok || STEP !== 3'd2) begin
            errors++;
            $display("FAIL abort_reach_step2: ok=%b step=%0d want step=2", ok, STEP);
        end
        START = 1'b0; ABORT = 1'b1; NEXT_FLAG = 1'b1; tick(); ABORT = 1'b0; NEXT_FLAG = 1'b0;
        checks++;
        if ({COMMAND, PATH, COMPARE_DISTANCE, RUN_FLAG, STEP, BUSY, DONE, ERROR} !== '0) begin
            errors++;
            $display("FAIL abort_mid_step: cmd=%b path=%0d cmp=%0d rf=%b step=%0d busy=%b want all zero",
                     COMMAND, PATH, COMPARE_DISTANCE, RUN_FLAG, STEP, BUSY);
        end
        drive_rand();
        tick();
        checks++;
        if (INITIAL_X !== 8'(sf) || INITIAL_Y !== 8'(f)) begin
            errors++;
            $display("FAIL abort_tracking: x=%0d y=%0d want x=%0d y=%0d", INITIAL_X, INITIAL_Y, sf, f);
        end
    endtask

    task automatic test_async_reset;
        drive_rand();
        START = 1'b1;
        tick(2);
        checks++;
        if (RUN_FLAG !== 2'b01 || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL areset_setup: rf=%b busy=%b want rf=01 busy=1", RUN_FLAG, BUSY);
        end
        #2 RESET = 1'b1;
        #1;
        checks++;
        if ({COMMAND, PATH, COMPARE_DISTANCE, RUN_FLAG, STEP, BUSY, DONE, ERROR, INITIAL_X, INITIAL_Y} !== '0) begin
            errors++;
            $display("FAIL areset_immediate: cmd=%b path=%0d cmp=%0d rf=%b busy=%b ix=%0d iy=%0d want all zero",
                     COMMAND, PATH, COMPARE_DISTANCE, RUN_FLAG, BUSY, INITIAL_X, INITIAL_Y);
        end
        START = 1'b0;
        tick(2);
        RESET = 1'b0;
        tick(3);
        checks++;
        if (RUN_FLAG !== 2'b00 || BUSY !== 1'b0 || COMMAND !== C_NONE || INITIAL_X !== 8'(sf)) begin
            errors++;
            $display("FAIL areset_release: rf=%b busy=%b cmd=%b ix=%0d want rf=00 busy=0 cmd=00000 ix=%0d",
                     RUN_FLAG, BUSY, COMMAND, INITIAL_X, sf);
        end
    endtask

    initial begin
        test_reset();
        test_capture_launch();
        test_confirm();
        test_timeout_retry();
        test_loop_limit();
        test_abort_saturation();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
